// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractcam rule writer: command codes, FSM states
// and the width of one write-enable group of the match block.
package fractcam_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_DELETE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int GROUP_W = 8;

endpackage

// File: rtl/fractcam_rule_writer_if.sv
// Host-side command channel of the rule writer: request handshake plus
// busy/done status. The host is the master, the writer the slave.
interface fractcam_rule_writer_if #(
    parameter int kw_size = 5,
    parameter int rd_size = 32
) ();
    localparam int row_w = $clog2(rd_size);

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [row_w-1:0]   req_row;
    logic [kw_size-1:0] req_key;
    logic [kw_size-1:0] req_mask;
    logic               busy;
    logic               done;

    modport master (
        output req_valid, req_op, req_row, req_key, req_mask,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_op, req_row, req_key, req_mask,
        output req_ready, busy, done
    );
endinterface

// File: rtl/fractcam_shadow_ram.sv
// Shadow copy of the match block: one word per key address, one bit per rule
// row. Registered read port; write is either a single bit or a full-word clear.
// A read and write to the same word in one cycle returns the old contents.
module fractcam_shadow_ram #(
    parameter int kw_size = 5,
    parameter int rd_size = 32,
    parameter int row_w   = $clog2(rd_size)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [kw_size-1:0] rd_addr,
    output logic [rd_size-1:0] rd_data,
    input  logic               wr_en,
    input  logic               clr_en,
    input  logic [kw_size-1:0] wr_addr,
    input  logic [row_w-1:0]   wr_row,
    input  logic               wr_bit
);
    localparam int depth = 1 << kw_size;

    logic [rd_size-1:0] mem_reg [depth];
    logic [rd_size-1:0] rd_data_reg;

    assign rd_data = rd_data_reg;

    // Registered read, then single-bit update or whole-word clear; reset wipes all.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < depth; i++) begin
                mem_reg[i] <= '0;
            end
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem_reg[rd_addr];
            if (clr_en) begin
                mem_reg[wr_addr] <= '0;
            end else if (wr_en) begin
                mem_reg[wr_addr][wr_row] <= wr_bit;
            end
        end
    end
endmodule

// File: rtl/fractcam_rule_writer.sv
// Turns one ternary rule command into a walk over every key address of the
// match block, writing the 8-bit column of the target row's group each cycle.
// The shadow RAM is read one address ahead so its registered output lines up
// with the address being written (read-modify-write without a stall).
module fractcam_rule_writer
    import fractcam_pkg::*;
#(
    parameter int kw_size = 5,
    parameter int rd_size = 32,
    parameter int we_size = rd_size / 8,
    parameter int row_w   = $clog2(rd_size)
) (
    input  logic                 wclk,
    input  logic                 rst,
    fractcam_rule_writer_if.slave cmd,
    output logic [kw_size-1:0]   sk,
    output logic                 clr,
    output logic [we_size-1:0]   we,
    output logic [GROUP_W-1:0]   rules
);
    localparam int gsh   = $clog2(GROUP_W);
    localparam int grp_w = row_w - gsh;

    state_e               state_reg, state_next;
    logic [kw_size-1:0]   addr_reg, addr_next;
    op_e                  op_reg;
    logic [row_w-1:0]     row_reg;
    logic [kw_size-1:0]   key_reg, mask_reg;

    logic [kw_size-1:0]   sk_reg, sk_next;
    logic                 clr_reg, clr_next;
    logic [we_size-1:0]   we_reg, we_next;
    logic [GROUP_W-1:0]   rules_reg, rules_next;
    logic                 done_reg, done_next;

    logic                 accept;
    logic [grp_w-1:0]     grp;
    logic [we_size-1:0]   grp_onehot;
    logic                 hit, new_bit;
    logic [kw_size-1:0]   rd_addr;
    logic [rd_size-1:0]   rd_data, word_new;
    logic                 wr_en, clr_en;

    assign cmd.req_ready = (state_reg == IDLE);
    assign cmd.busy      = (state_reg != IDLE);
    assign cmd.done      = done_reg;
    assign accept        = cmd.req_valid && (state_reg == IDLE);

    assign sk    = sk_reg;
    assign clr   = clr_reg;
    assign we    = we_reg;
    assign rules = rules_reg;

    assign grp = row_reg[row_w-1:gsh];
    assign hit = ((addr_reg ^ key_reg) & ~mask_reg) == '0;

    generate
        for (genvar gi = 0; gi < we_size; gi++) begin : g_onehot
            assign grp_onehot[gi] = (grp == grp_w'(gi));
        end
    endgenerate

    fractcam_shadow_ram #(
        .kw_size (kw_size),
        .rd_size (rd_size),
        .row_w   (row_w)
    ) u_shadow (
        .clk     (wclk),
        .srst    (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .clr_en  (clr_en),
        .wr_addr (addr_reg),
        .wr_row  (row_reg),
        .wr_bit  (new_bit)
    );

    // State, walk address, latched command and registered write-side outputs.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            op_reg    <= OP_INSERT;
            row_reg   <= '0;
            key_reg   <= '0;
            mask_reg  <= '0;
            sk_reg    <= '0;
            clr_reg   <= 1'b0;
            we_reg    <= '0;
            rules_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            sk_reg    <= sk_next;
            clr_reg   <= clr_next;
            we_reg    <= we_next;
            rules_reg <= rules_next;
            done_reg  <= done_next;
            if (accept) begin
                op_reg   <= op_e'(cmd.req_op);
                row_reg  <= cmd.req_row;
                key_reg  <= cmd.req_key;
                mask_reg <= cmd.req_mask;
            end
        end
    end

    // Next state, shadow access and next write-side outputs for the current address.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        sk_next    = sk_reg;
        rules_next = rules_reg;
        clr_next   = 1'b0;
        we_next    = '0;
        done_next  = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        clr_en     = 1'b0;
        new_bit    = 1'b0;
        word_new   = rd_data;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next  = '0;
                    state_next = (cmd.req_op == OP_RSVD) ? DONE : WRITE;
                end
            end
            WRITE: begin
                rd_addr   = kw_size'(addr_reg + 1'b1);
                sk_next   = addr_reg;
                addr_next = kw_size'(addr_reg + 1'b1);
                if (addr_reg == '1) begin
                    state_next = DONE;
                end
                if (op_reg == OP_CLEAR) begin
                    clr_en     = 1'b1;
                    we_next    = '1;
                    rules_next = '0;
                    clr_next   = (addr_reg == '0);
                end else begin
                    wr_en             = 1'b1;
                    new_bit           = (op_reg == OP_INSERT) && hit;
                    word_new[row_reg] = new_bit;
                    we_next           = grp_onehot;
                    rules_next        = word_new[grp*GROUP_W +: GROUP_W];
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fractcam_rule_writer.sv
// Bench for fractcam_rule_writer: directed commands from the test plan plus a
// random command stream, checked against a per-row rule model (valid/key/mask).
module tb_fractcam_rule_writer;
    logic       wclk;
    logic       rst;
    logic [4:0] sk;
    logic       clr;
    logic [3:0] we;
    logic [7:0] rules;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_accept = 0;
    bit expect_b2b  = 0;

    // Reference model: one ternary rule per row.
    bit         m_valid [32];
    logic [4:0] m_key   [32];
    logic [4:0] m_mask  [32];

    fractcam_rule_writer_if #(.kw_size(5), .rd_size(32)) cmd ();

    fractcam_rule_writer #(
        .kw_size (5),
        .rd_size (32)
    ) dut (
        .wclk  (wclk),
        .rst   (rst),
        .cmd   (cmd),
        .sk    (sk),
        .clr   (clr),
        .we    (we),
        .rules (rules)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_col(input int a, input int g);
        logic [7:0] col;
        logic [4:0] av;
        int r;
        av = a[4:0];
        for (int j = 0; j < 8; j++) begin
            r = g * 8 + j;
            col[j] = m_valid[r] && (((av ^ m_key[r]) & ~m_mask[r]) == 5'd0);
        end
        return col;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_valid[r] = 1'b0;
            m_key[r]   = '0;
            m_mask[r]  = '0;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [4:0] key,
                           input logic [4:0] mask, input bit hold, input int abort_at);
        logic [3:0] ewe;
        logic [7:0] erules;
        int g;
        g = int'(row[4:3]);
        $display("cmd op=%0d row=%0d key=%05b mask=%05b hold=%0d abort_at=%0d",
                 op, row, key, mask, hold, abort_at);
        @(negedge wclk);
        check("ready_idle", cmd.req_ready, 1);
        cmd.req_valid = 1'b1;
        cmd.req_op    = op;
        cmd.req_row   = row;
        cmd.req_key   = key;
        cmd.req_mask  = mask;
        @(posedge wclk);
        #1;
        if (!hold) cmd.req_valid = 1'b0;
        if (expect_b2b) check("b2b_spacing", cyc - last_accept, 34);
        expect_b2b  = hold;
        last_accept = cyc;
        check("busy_accept", cmd.busy, 1);
        check("ready_accept", cmd.req_ready, 0);
        case (op)
            2'b00: begin m_valid[row] = 1'b1; m_key[row] = key; m_mask[row] = mask; end
            2'b01: m_valid[row] = 1'b0;
            2'b10: model_clear();
            default: ;
        endcase
        if (op != 2'b11) begin
            for (int i = 0; i < 32; i++) begin
                @(posedge wclk);
                #1;
                if (op == 2'b10) begin
                    ewe    = 4'hF;
                    erules = 8'h00;
                end else begin
                    ewe    = 4'b0001 << g;
                    erules = exp_col(i, g);
                end
                check("walk_sk", sk, i);
                check("walk_we", we, ewe);
                check("walk_rules", rules, erules);
                check("walk_clr", clr, (op == 2'b10 && i == 0) ? 1 : 0);
                check("walk_done", cmd.done, 0);
                check("walk_ready", cmd.req_ready, 0);
                if (i == abort_at) begin
                    @(negedge wclk);
                    rst = 1'b1;
                    cmd.req_valid = 1'b0;
                    @(posedge wclk);
                    #1;
                    check("abort_we", we, 0);
                    check("abort_busy", cmd.busy, 0);
                    check("abort_done", cmd.done, 0);
                    check("abort_clr", clr, 0);
                    @(negedge wclk);
                    rst = 1'b0;
                    model_clear();
                    expect_b2b = 0;
                    for (int k = 0; k < 4; k++) begin
                        @(posedge wclk);
                        #1;
                        check("abort_no_done", cmd.done, 0);
                        check("abort_idle_we", we, 0);
                    end
                    return;
                end
            end
        end
        @(posedge wclk);
        #1;
        check("done_pulse", cmd.done, 1);
        check("done_we", we, 0);
        check("done_clr", clr, 0);
        check("done_ready", cmd.req_ready, 1);
        check("done_busy", cmd.busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        cmd.req_valid = 1'b0;
        cmd.req_op    = 2'b00;
        cmd.req_row   = '0;
        cmd.req_key   = '0;
        cmd.req_mask  = '0;
        model_clear();
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        rst = 1'b0;
        @(posedge wclk);
        #1;
        check("rst_ready", cmd.req_ready, 1);
        check("rst_busy", cmd.busy, 0);
        check("rst_done", cmd.done, 0);
        check("rst_we", we, 0);
        check("rst_clr", clr, 0);
        check("rst_sk", sk, 0);
        check("rst_rules", rules, 0);

        // Directed test-plan sequence.
        run_cmd(2'b10, 5'd0,  5'b00000, 5'b00000, 0, -1);
        run_cmd(2'b00, 5'd3,  5'b10100, 5'b00011, 0, -1);
        run_cmd(2'b00, 5'd9,  5'b00000, 5'b11111, 0, -1);
        run_cmd(2'b00, 5'd10, 5'b00001, 5'b00000, 0, -1);
        run_cmd(2'b01, 5'd9,  5'b00000, 5'b00000, 0, -1);
        run_cmd(2'b01, 5'd17, 5'b00000, 5'b00000, 0, -1);
        // Valid held through a walk, then a back-to-back command.
        run_cmd(2'b00, 5'd20, 5'b01101, 5'b10000, 1, -1);
        run_cmd(2'b00, 5'd3,  5'b00111, 5'b00000, 0, -1);
        run_cmd(2'b11, 5'd4,  5'b11111, 5'b00000, 0, -1);

        // Random command stream.
        for (int n = 0; n < 12; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 0, -1);
        end

        // Reset in the middle of a walk, then recover.
        run_cmd(2'b00, 5'd5,  5'b11000, 5'b00111, 0, 12);
        run_cmd(2'b10, 5'd0,  5'b00000, 5'b00000, 0, -1);
        run_cmd(2'b00, 5'd30, 5'b01010, 5'b00100, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
